// File: rtl/sched_pkg.sv
// Shared types for the row-FIFO skew scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/fifo_skew_scheduler.sv
// Diagonal-skew read controller for ROWS row FIFOs feeding the systolic array.
// Latency: r_en combinational; row_valid/arr_en one cycle after r_en (registered FIFO read).
// Backpressure: any empty FIFO on a due row stalls the whole wavefront; step and r_en hold.
module fifo_skew_scheduler
    import sched_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic [ROWS-1:0]  fifo_empty,
    output logic [ROWS-1:0]  fifo_r_en,
    output logic [ROWS-1:0]  row_valid,
    output logic             arr_en,
    output logic             busy,
    output logic             done
);

    // Wide enough for len_q + ROWS - 1 without wrap.
    localparam int SW = LEN_W + $clog2(ROWS) + 1;

    sched_state_t     state, state_d;
    logic [SW-1:0]    step;
    logic [LEN_W-1:0] len_q;
    logic [SW-1:0]    last_step;
    logic [ROWS-1:0]  due;
    logic             stall_hit;
    logic             advance;
    logic             abort_hit;

    // Row i reads during the window i <= step < i + len_q.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_due
            assign due[gi] = (step >= SW'(gi)) && (step < (SW'(gi) + SW'(len_q)));
        end
    endgenerate

    assign last_step = SW'(len_q) + SW'(ROWS - 2);
    assign stall_hit = |(due & fifo_empty);
    assign advance   = (state == S_RUN) && !stall_hit;
    assign fifo_r_en = advance ? due : '0;
    assign abort_hit = abort && ((state == S_RUN) || (state == S_FLUSH));
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // Next-state decode; start is only honoured in IDLE, abort only in RUN/FLUSH.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start) state_d = (len != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                if (abort)                                state_d = S_IDLE;
                else if (advance && (step == last_step))  state_d = S_FLUSH;
            end
            S_FLUSH: state_d = abort ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, step counter, latched length and the one-cycle-delayed valids.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            step      <= '0;
            len_q     <= '0;
            row_valid <= '0;
            arr_en    <= 1'b0;
        end else begin
            state <= state_d;
            if (state == S_IDLE) begin
                step <= '0;
                if (start) len_q <= len;
            end else if (advance) begin
                step <= step + 1'b1;
            end
            row_valid <= abort_hit ? '0 : fifo_r_en;
            arr_en    <= abort_hit ? 1'b0 : advance;
        end
    end

endmodule

// File: tb/tb_fifo_skew_scheduler.sv
// Directed, table-driven bench for fifo_skew_scheduler (ROWS=4, LEN_W=8).
// One vector per cycle: inputs driven just after posedge, outputs checked at negedge.
// Abort and mid-job reset are hand-written sequences reusing the same apply task.
module tb_fifo_skew_scheduler;

    localparam int ROWS  = 4;
    localparam int LEN_W = 8;

    typedef struct {
        logic             rstn;
        logic             start;
        logic [LEN_W-1:0] len;
        logic             abort;
        logic [ROWS-1:0]  empty;
        logic [ROWS-1:0]  exp_r_en;
        logic [ROWS-1:0]  exp_rv;
        logic             exp_arr;
        logic             exp_busy;
        logic             exp_done;
    } vec_t;

    logic             clk;
    logic             rstn;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic [ROWS-1:0]  fifo_empty;
    logic [ROWS-1:0]  fifo_r_en;
    logic [ROWS-1:0]  row_valid;
    logic             arr_en;
    logic             busy;
    logic             done;

    int n_vec;
    int n_bad;

    vec_t tbl[$];
    vec_t t1[$];

    fifo_skew_scheduler #(.ROWS(ROWS), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .row_valid  (row_valid),
        .arr_en     (arr_en),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rs, input logic st, input logic [LEN_W-1:0] ln,
                                input logic ab, input logic [ROWS-1:0] em,
                                input logic [ROWS-1:0] r, input logic [ROWS-1:0] rv,
                                input logic ar, input logic bz, input logic dn);
        vec_t v;
        v.rstn = rs; v.start = st; v.len = ln; v.abort = ab; v.empty = em;
        v.exp_r_en = r; v.exp_rv = rv; v.exp_arr = ar; v.exp_busy = bz; v.exp_done = dn;
        return v;
    endfunction

    // Drive one cycle of inputs, compare outputs mid-cycle, step to the next cycle.
    task automatic apply(input vec_t v, input string name, input int idx);
        rstn       = v.rstn;
        start      = v.start;
        len        = v.len;
        abort      = v.abort;
        fifo_empty = v.empty;
        @(negedge clk);
        n_vec++;
        if (fifo_r_en !== v.exp_r_en || row_valid !== v.exp_rv || arr_en !== v.exp_arr ||
            busy !== v.exp_busy || done !== v.exp_done) begin
            n_bad++;
            $display("FAIL %s[%0d]: got r_en=%b rv=%b arr=%b busy=%b done=%b, want r_en=%b rv=%b arr=%b busy=%b done=%b",
                     name, idx, fifo_r_en, row_valid, arr_en, busy, done,
                     v.exp_r_en, v.exp_rv, v.exp_arr, v.exp_busy, v.exp_done);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rstn = 1'b0; start = 1'b0; len = '0; abort = 1'b0; fifo_empty = '0;

        // Test 1: all FIFOs full, len=3 (cycle 0 = start cycle, also checks reset/idle outputs).
        t1.push_back(mk(1,1,3,0,4'b0000, 4'b0000,4'b0000,0,0,0)); // c0
        t1.push_back(mk(1,0,0,0,4'b0000, 4'b0001,4'b0000,0,1,0)); // c1
        t1.push_back(mk(1,0,0,0,4'b0000, 4'b0011,4'b0001,1,1,0)); // c2
        t1.push_back(mk(1,0,0,0,4'b0000, 4'b0111,4'b0011,1,1,0)); // c3
        t1.push_back(mk(1,0,0,0,4'b0000, 4'b1110,4'b0111,1,1,0)); // c4
        t1.push_back(mk(1,0,0,0,4'b0000, 4'b1100,4'b1110,1,1,0)); // c5
        t1.push_back(mk(1,0,0,0,4'b0000, 4'b1000,4'b1100,1,1,0)); // c6
        t1.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b1000,1,1,0)); // c7 FLUSH
        t1.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,1,1)); // c8 DONE
        t1.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,0,0)); // c9 IDLE
        foreach (t1[i]) tbl.push_back(t1[i]);

        // Test 2: row 2 empty in cycles 3..4 stalls the wavefront.
        tbl.push_back(mk(1,1,3,0,4'b0000, 4'b0000,4'b0000,0,0,0)); // c0
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0001,4'b0000,0,1,0)); // c1
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0011,4'b0001,1,1,0)); // c2
        tbl.push_back(mk(1,0,0,0,4'b0100, 4'b0000,4'b0011,1,1,0)); // c3 stall
        tbl.push_back(mk(1,0,0,0,4'b0100, 4'b0000,4'b0000,0,1,0)); // c4 stall
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0111,4'b0000,0,1,0)); // c5
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b1110,4'b0111,1,1,0)); // c6
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b1100,4'b1110,1,1,0)); // c7
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b1000,4'b1100,1,1,0)); // c8
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b1000,1,1,0)); // c9
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,1,1)); // c10
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,0,0)); // c11

        // Test 3: len=0 goes straight to DONE with no reads.
        tbl.push_back(mk(1,1,0,0,4'b0000, 4'b0000,4'b0000,0,0,0)); // c0
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,1,1)); // c1
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,0,0)); // c2

        // Test 4: start with len=5 during RUN ignored; empty on a not-yet-due row (3) does not stall.
        tbl.push_back(mk(1,1,3,0,4'b0000, 4'b0000,4'b0000,0,0,0)); // c0
        tbl.push_back(mk(1,0,0,0,4'b1000, 4'b0001,4'b0000,0,1,0)); // c1
        tbl.push_back(mk(1,1,5,0,4'b0000, 4'b0011,4'b0001,1,1,0)); // c2
        tbl.push_back(mk(1,1,5,0,4'b0000, 4'b0111,4'b0011,1,1,0)); // c3
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b1110,4'b0111,1,1,0)); // c4
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b1100,4'b1110,1,1,0)); // c5
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b1000,4'b1100,1,1,0)); // c6
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b1000,1,1,0)); // c7
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,1,1)); // c8
        tbl.push_back(mk(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,0,0)); // c9

        // Reset for two edges, then release just after a posedge.
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        foreach (tbl[i]) apply(tbl[i], "table", i);

        // Test 5: abort in cycle 4, then a clean rerun.
        for (int i = 0; i < 4; i++) apply(t1[i], "abort_pre", i);
        apply(mk(1,0,0,1,4'b0000, 4'b1110,4'b0111,1,1,0), "abort_c4", 4);
        for (int i = 5; i < 10; i++)
            apply(mk(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,0,0), "abort_post", i);
        foreach (t1[i]) apply(t1[i], "abort_rerun", i);

        // Test 6: synchronous reset during cycle 3 kills the job; then a clean rerun.
        for (int i = 0; i < 3; i++) apply(t1[i], "rst_pre", i);
        apply(mk(0,0,0,0,4'b0000, 4'b0111,4'b0011,1,1,0), "rst_c3", 3);
        for (int i = 4; i < 10; i++)
            apply(mk(1,0,0,0,4'b0000, 4'b0000,4'b0000,0,0,0), "rst_post", i);
        foreach (t1[i]) apply(t1[i], "rst_rerun", i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
